// File: rtl/rega_timer_bcd_if.sv
// Control/status bundle for the irrigation countdown timer.
// The timer sits on the slave side and the controller on the master side.
interface rega_timer_bcd_if;
  logic       start;
  logic       stop;
  logic [3:0] preset_tens;
  logic [3:0] preset_units;
  logic [3:0] tens;
  logic [3:0] units;
  logic       borrow;
  logic       valve;
  logic       done;
  logic       err;
  logic [7:0] seg_tens;
  logic [7:0] seg_units;

  modport master (
    output start, stop, preset_tens, preset_units,
    input  tens, units, borrow, valve, done, err, seg_tens, seg_units
  );

  modport slave (
    input  start, stop, preset_tens, preset_units,
    output tens, units, borrow, valve, done, err, seg_tens, seg_units
  );
endinterface

// File: rtl/rega_timer_bcd.sv
// Two-digit BCD irrigation countdown timer with valve drive and 7-segment encoding.
// The prescaler divides clk into time units; a units wrap 0->9 borrows from the tens digit.
module rega_timer_bcd #(
  parameter int unsigned TICK_DIV = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  rega_timer_bcd_if.slave bus
);

  localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    tens_q, tens_d;
  logic [3:0]    units_q, units_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          borrow_q, borrow_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          valve_q, valve_d;

  logic          preset_ok;
  logic          tick;
  logic          last_unit;

  // 00 is rejected as well as non-BCD codes: there would be nothing to count.
  assign preset_ok = (bus.preset_tens <= 4'd9) && (bus.preset_units <= 4'd9) &&
                     !((bus.preset_tens == 4'd0) && (bus.preset_units == 4'd0));
  assign tick      = (presc_q == PRESC_LAST);
  assign last_unit = (tens_q == 4'd0) && (units_q == 4'd1);

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      tens_q   <= 4'd0;
      units_q  <= 4'd0;
      presc_q  <= '0;
      borrow_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      valve_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      tens_q   <= tens_d;
      units_q  <= units_d;
      presc_q  <= presc_d;
      borrow_q <= borrow_d;
      done_q   <= done_d;
      err_q    <= err_d;
      valve_q  <= valve_d;
    end
  end

  // Next-state, countdown and pulse generation
  always_comb begin
    state_d  = state_q;
    tens_d   = tens_q;
    units_d  = units_q;
    presc_d  = presc_q;
    borrow_d = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (preset_ok) begin
            tens_d  = bus.preset_tens;
            units_d = bus.preset_units;
            presc_d = '0;
            state_d = RUN;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      RUN: begin
        // Stop freezes everything, including a tick landing on the same edge.
        if (bus.stop) begin
          state_d = HOLD;
        end else if (tick) begin
          presc_d = '0;
          if (units_q == 4'd0) begin
            units_d  = 4'd9;
            tens_d   = tens_q - 4'd1;
            borrow_d = 1'b1;
          end else begin
            units_d = units_q - 4'd1;
          end
          if (last_unit) begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end

      HOLD: begin
        // Stop takes priority so Start+Stop aborts rather than resumes.
        if (bus.stop) begin
          tens_d  = 4'd0;
          units_d = 4'd0;
          state_d = IDLE;
        end else if (bus.start) begin
          state_d = RUN;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Valve mirrors the registered state, so it is driven from the next state.
  assign valve_d = (state_d == RUN);

  function automatic logic [7:0] seg7(input logic [3:0] d);
    logic [7:0] s;
    unique case (d)
      4'd0:    s = 8'hC0;
      4'd1:    s = 8'hF9;
      4'd2:    s = 8'hA4;
      4'd3:    s = 8'hB0;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h92;
      4'd6:    s = 8'h82;
      4'd7:    s = 8'hF8;
      4'd8:    s = 8'h80;
      4'd9:    s = 8'h90;
      default: s = 8'hFF;
    endcase
    return s;
  endfunction

  assign bus.tens      = tens_q;
  assign bus.units     = units_q;
  assign bus.borrow    = borrow_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.valve     = valve_q;
  assign bus.seg_tens  = seg7(tens_q);
  assign bus.seg_units = seg7(units_q);

endmodule

// File: tb/tb_rega_timer_bcd.sv
// Directed bench for rega_timer_bcd: one instance at TICK_DIV=4, one at TICK_DIV=2.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_rega_timer_bcd;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  int   borrows;
  int   ev;

  logic [7:0] seg_tbl [0:9] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  rega_timer_bcd_if bus_a ();
  rega_timer_bcd_if bus_b ();

  rega_timer_bcd #(.TICK_DIV(4)) u_dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  rega_timer_bcd #(.TICK_DIV(2)) u_dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start_a(input logic [3:0] t, input logic [3:0] u);
    bus_a.preset_tens  = t;
    bus_a.preset_units = u;
    bus_a.start        = 1'b1;
    step(1);
    bus_a.start        = 1'b0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    bus_a.start = 1'b0; bus_a.stop = 1'b0; bus_a.preset_tens = 4'd0; bus_a.preset_units = 4'd0;
    bus_b.start = 1'b0; bus_b.stop = 1'b0; bus_b.preset_tens = 4'd0; bus_b.preset_units = 4'd0;
    step(2);

    // Reset state
    chk("rst_tens",   8'(bus_a.tens), 8'd0);
    chk("rst_units",  8'(bus_a.units), 8'd0);
    chk("rst_valve",  8'(bus_a.valve), 8'd0);
    chk("rst_done",   8'(bus_a.done), 8'd0);
    chk("rst_segt",   bus_a.seg_tens, 8'hC0);
    chk("rst_segu",   bus_a.seg_units, 8'hC0);
    rst_n = 1'b1;
    step(1);

    // Preset 1,2 full run at TICK_DIV=4
    start_a(4'd1, 4'd2);
    chk("p2_valve_on", 8'(bus_a.valve), 8'd1);
    chk("p2_load",     {bus_a.tens, bus_a.units}, 8'h12);
    step(4);
    chk("p2_first_dec", {bus_a.tens, bus_a.units}, 8'h11);
    chk("p2_no_borrow", 8'(bus_a.borrow), 8'd0);
    step(8);
    chk("p2_wrap",      {bus_a.tens, bus_a.units}, 8'h09);
    chk("p2_borrow",    8'(bus_a.borrow), 8'd1);
    chk("p2_segu_9",    bus_a.seg_units, 8'h90);
    chk("p2_segt_0",    bus_a.seg_tens, 8'hC0);
    step(1);
    chk("p2_borrow_end", 8'(bus_a.borrow), 8'd0);
    step(34);
    chk("p2_pre_done",  8'(bus_a.done), 8'd0);
    chk("p2_pre_digit", {bus_a.tens, bus_a.units}, 8'h01);
    step(1);
    chk("p2_done",      8'(bus_a.done), 8'd1);
    chk("p2_valve_off", 8'(bus_a.valve), 8'd0);
    chk("p2_zero",      {bus_a.tens, bus_a.units}, 8'h00);
    step(1);
    chk("p2_done_end",  8'(bus_a.done), 8'd0);

    // Preset 0,9 with a pause while the prescaler holds partial credit
    start_a(4'd0, 4'd9);
    step(8);
    chk("p3_at7",       {bus_a.tens, bus_a.units}, 8'h07);
    step(2);
    bus_a.stop = 1'b1;
    step(1);
    bus_a.stop = 1'b0;
    chk("p3_hold_valve", 8'(bus_a.valve), 8'd0);
    chk("p3_hold_digit", {bus_a.tens, bus_a.units}, 8'h07);
    step(19);
    chk("p3_hold_long",  {bus_a.tens, bus_a.units}, 8'h07);
    chk("p3_hold_nobrw", 8'(bus_a.borrow), 8'd0);
    chk("p3_hold_valve2", 8'(bus_a.valve), 8'd0);
    bus_a.start = 1'b1;
    step(1);
    bus_a.start = 1'b0;
    chk("p3_resume_valve", 8'(bus_a.valve), 8'd1);
    step(1);
    chk("p3_credit_pre", 8'(bus_a.units), 8'd7);
    step(1);
    chk("p3_credit_dec", 8'(bus_a.units), 8'd6);
    step(23);
    chk("p3_pre_done",   8'(bus_a.done), 8'd0);
    step(1);
    chk("p3_done",       8'(bus_a.done), 8'd1);
    chk("p3_zero",       {bus_a.tens, bus_a.units}, 8'h00);
    step(1);

    // Abort from HOLD with Stop, then Start+Stop together in RUN
    start_a(4'd0, 4'd5);
    bus_a.stop = 1'b1;
    step(1);
    chk("p4_hold_valve", 8'(bus_a.valve), 8'd0);
    chk("p4_hold_digit", 8'(bus_a.units), 8'd5);
    step(1);
    bus_a.stop = 1'b0;
    chk("p4_abort_digit", {bus_a.tens, bus_a.units}, 8'h00);
    chk("p4_abort_done",  8'(bus_a.done), 8'd0);
    step(3);
    chk("p4_no_done",     8'(bus_a.done), 8'd0);
    chk("p4_idle_valve",  8'(bus_a.valve), 8'd0);
    start_a(4'd0, 4'd5);
    bus_a.start = 1'b1;
    bus_a.stop  = 1'b1;
    step(1);
    chk("p4_both_hold",  8'(bus_a.valve), 8'd0);
    chk("p4_both_digit", 8'(bus_a.units), 8'd5);
    step(1);
    bus_a.start = 1'b0;
    bus_a.stop  = 1'b0;
    chk("p4_both_abort", {bus_a.tens, bus_a.units}, 8'h00);
    chk("p4_both_valve", 8'(bus_a.valve), 8'd0);
    chk("p4_both_nobrw", 8'(bus_a.borrow), 8'd0);
    step(1);

    // Rejected presets
    start_a(4'hA, 4'd3);
    chk("p5_err_a3",   8'(bus_a.err), 8'd1);
    chk("p5_valve_a3", 8'(bus_a.valve), 8'd0);
    chk("p5_dig_a3",   {bus_a.tens, bus_a.units}, 8'h00);
    step(1);
    chk("p5_err_end",  8'(bus_a.err), 8'd0);
    start_a(4'd0, 4'd0);
    chk("p5_err_00",   8'(bus_a.err), 8'd1);
    chk("p5_valve_00", 8'(bus_a.valve), 8'd0);
    step(1);
    chk("p5_err_end2", 8'(bus_a.err), 8'd0);
    chk("p5_still_idle", 8'(bus_a.valve), 8'd0);

    // Async reset mid-count, then a fresh run
    start_a(4'd3, 4'd7);
    step(1);
    chk("p1_running", {bus_a.tens, bus_a.units}, 8'h37);
    #2 rst_n = 1'b0;
    #1;
    chk("p1_rst_digit", {bus_a.tens, bus_a.units}, 8'h00);
    chk("p1_rst_valve", 8'(bus_a.valve), 8'd0);
    chk("p1_rst_segt",  bus_a.seg_tens, 8'hC0);
    chk("p1_rst_segu",  bus_a.seg_units, 8'hC0);
    step(1);
    rst_n = 1'b1;
    step(1);
    start_a(4'd0, 4'd2);
    chk("p1_fresh_load",  {bus_a.tens, bus_a.units}, 8'h02);
    chk("p1_fresh_valve", 8'(bus_a.valve), 8'd1);
    step(4);
    chk("p1_fresh_dec",   8'(bus_a.units), 8'd1);
    step(4);
    chk("p1_fresh_done",  8'(bus_a.done), 8'd1);
    step(1);

    // Preset 9,9 full run at TICK_DIV=2
    bus_b.preset_tens  = 4'd9;
    bus_b.preset_units = 4'd9;
    bus_b.start        = 1'b1;
    step(1);
    bus_b.start        = 1'b0;
    chk("p6_load",  {bus_b.tens, bus_b.units}, 8'h99);
    chk("p6_valve", 8'(bus_b.valve), 8'd1);
    borrows = 0;
    for (int k = 1; k <= 199; k++) begin
      step(1);
      ev = (k <= 198) ? (99 - k / 2) : 0;
      if (bus_b.borrow) borrows++;
      chk("p6_tens",  8'(bus_b.tens), 8'(ev / 10));
      chk("p6_units", 8'(bus_b.units), 8'(ev % 10));
      chk("p6_segt",  bus_b.seg_tens, seg_tbl[ev / 10]);
      chk("p6_segu",  bus_b.seg_units, seg_tbl[ev % 10]);
      chk("p6_borrow", 8'(bus_b.borrow), 8'((k % 2 == 0) && (k <= 198) && (ev % 10 == 9)));
      chk("p6_done",  8'(bus_b.done), 8'(k == 198));
      chk("p6_valve", 8'(bus_b.valve), 8'(k < 198));
    end
    chk("p6_borrow_count", 8'(borrows), 8'd9);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rega_timer_bcd.md
Name: rega_timer_bcd

Overview:
- Two-digit BCD irrigation countdown timer (00-99 time units) that drives the irrigation valve.
- Divides Clk into a time-unit tick and decrements a units digit.
- Emits a one-cycle Borrow each time the units digit wraps 0->9, which decrements the tens digit.
- Encodes both digits for 8-bit 7-segment displays, the same format as the display outputs used elsewhere in the design.

Parameters:
TICK_DIV, 4, Clk cycles per time unit (>=2); prescaler width = clog2(TICK_DIV).

Ports:
Clk  input  1  system clock, rising edge
Rst_n  input  1  asynchronous active-low reset
Start  input  1  level, sampled each edge: load and run from IDLE, resume from HOLD
Stop  input  1  level, sampled each edge: pause in RUN, abort in HOLD
Preset_Tens  input  4  BCD tens preset, sampled on accepted Start in IDLE
Preset_Units  input  4  BCD units preset, sampled on accepted Start in IDLE
Tens  output  4  current tens digit
Units  output  4  current units digit
Borrow  output  1  one-cycle pulse on units wrap 0->9
Valve  output  1  1 while state==RUN
Done  output  1  one-cycle pulse at countdown completion
Err  output  1  one-cycle pulse on rejected preset
Seg_Tens  output  8  active-low {dp,g,f,e,d,c,b,a} for Tens
Seg_Units  output  8  active-low {dp,g,f,e,d,c,b,a} for Units

Behaviour:
- Reset (async, immediate on Rst_n=0): state=IDLE; Tens=Units=0; prescaler=0; Borrow=Done=Err=Valve=0; Seg_Tens=Seg_Units=8'hC0. Reset mid-count discards all progress.
- FSM states: IDLE, RUN, HOLD, DONE. All outputs except Seg_* are registered.
- IDLE, Start=1:
  - Valid preset (both digits <=9 and not 00): load digits, prescaler=0, go to RUN next edge.
  - Invalid preset: Err=1 for one cycle, stay IDLE, digits unchanged.
- RUN, prescaler behaviour:
  - Prescaler counts 0..TICK_DIV-1 and wraps; tick = (prescaler==TICK_DIV-1).
  - On a tick with Units!=0: Units-1.
  - On a tick with Units==0: Units=9, Tens-1, Borrow=1 next cycle.
  - Tick that makes the value 00: next state DONE.
  - First decrement occurs TICK_DIV cycles after entering RUN.
- RUN, controls:
  - Stop=1: go to HOLD. Prescaler and digits freeze; a coincident tick is ignored.
  - Start=1 alone: ignored.
  - Start=1 and Stop=1 together: Stop wins.
- HOLD:
  - Start=1 (Stop=0): resume RUN with the prescaler value retained.
  - Stop=1: abort to IDLE with Tens=Units=0; no Done.
  - Start and Stop together: abort.
- DONE: Done=1 for exactly one cycle, Valve=0, digits stay 00, go to IDLE next edge. Start/Stop are ignored in DONE.
- Valve reflects the state register: it rises the cycle after Start is accepted and falls the cycle DONE/HOLD is entered.
- Segment encoding: combinational from the Tens/Units registers. dp always 1 (off).
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90.
  - Any code >9 displays FF (blank); unreachable in legal operation.
- Borrow is produced only by the RUN decrement; never on load, abort or reset.
- Total run time from accepted Start to Done: (10*Tens+Units)*TICK_DIV cycles plus 1 cycle of state entry, excluding HOLD time.

Test Plan:
1. Rst_n=0 asserted asynchronously mid-RUN at digits 3,7 -> same instant Tens=Units=0, Valve=0, Seg_Tens=Seg_Units=C0; Start after release begins a fresh count.
2. TICK_DIV=4, preset 1,2, Start -> Valve=1 next cycle; 1,1 after 4 cycles; at 1,0->0,9 Borrow pulses 1 cycle and Seg_Units=90, Seg_Tens=C0; Done pulses after 48 cycles of RUN; Valve=0 and IDLE.
3. Preset 0,9 running; Stop at 0,7 for 20 cycles -> digits hold 0,7, Valve=0, no Borrow; Start resumes and Done arrives exactly 7*4 cycles of RUN later, counting the partial prescaler credit.
4. In HOLD assert Stop again -> IDLE, digits 0,0, Done never pulses; Start+Stop in the same RUN cycle -> HOLD, not resume.
5. Preset A,3 then 0,0 with Start -> Err pulses once per attempt, state stays IDLE, Valve stays 0, digits unchanged.
6. Preset 9,9 full run with TICK_DIV=2 -> exactly 9 Borrow pulses, segments walk 9..0 with correct codes, Done after 198 RUN cycles.
